// File: rtl/mem_arb_pkg.sv
// Shared widths, types and FSM states for the instruction/data memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BE_W-1:0]   be_t;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D,
        RESP
    } arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signals of the arbiter, bundled with direction views.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic  if_req;
    addr_t if_addr;
    logic  if_ack;
    data_t if_rdata;

    logic  d_req;
    be_t   d_we;
    addr_t d_addr;
    data_t d_wdata;
    logic  d_ack;
    data_t d_rdata;

    logic  err;

    logic  mem_req;
    addr_t mem_addr;
    data_t mem_wdata;
    be_t   mem_we;
    logic  mem_ready;
    data_t mem_rdata;

    modport master (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output if_ack, if_rdata,
        output d_ack, d_rdata, err,
        output mem_req, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  if_ack, if_rdata,
        input  d_ack, d_rdata, err,
        input  mem_req, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/arb_wait_timer.sv
// Counts stalled grant cycles; expired flags the cycle that would reach TIMEOUT.
module arb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expired = enable && (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single memory port; data has priority,
// bounded by a streak counter so fetches cannot starve.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_BURST = 4,
    parameter int TIMEOUT    = 16
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    localparam int SW = $clog2(DATA_BURST + 1);
    localparam logic [SW-1:0] BURST_MAX = SW'(DATA_BURST);

    arb_state_e    state, state_n;
    logic [SW-1:0] streak, streak_n;

    logic  mem_req_n, if_ack_n, d_ack_n, err_n;
    addr_t addr_n;
    data_t wdata_n, if_rdata_n, d_rdata_n;
    be_t   we_n;

    logic granted, d_wins, done, expired;

    assign granted = (state == GNT_I) || (state == GNT_D);
    assign d_wins  = bus.d_req && !(bus.if_req && streak == BURST_MAX);
    assign done    = bus.mem_ready || expired;

    arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  (granted && !bus.mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_n    = state;
        streak_n   = streak;
        mem_req_n  = bus.mem_req;
        addr_n     = bus.mem_addr;
        wdata_n    = bus.mem_wdata;
        we_n       = bus.mem_we;
        if_rdata_n = bus.if_rdata;
        d_rdata_n  = bus.d_rdata;
        if_ack_n   = 1'b0;
        d_ack_n    = 1'b0;
        err_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_wins) begin
                    state_n   = GNT_D;
                    mem_req_n = 1'b1;
                    addr_n    = bus.d_addr;
                    wdata_n   = bus.d_wdata;
                    we_n      = bus.d_we;
                    if (bus.if_req && streak != BURST_MAX) begin
                        streak_n = streak + SW'(1);
                    end
                end else if (bus.if_req) begin
                    state_n   = GNT_I;
                    mem_req_n = 1'b1;
                    addr_n    = bus.if_addr;
                    wdata_n   = '0;
                    we_n      = '0;
                    streak_n  = '0;
                end
            end
            GNT_I: begin
                if (done) begin
                    state_n   = RESP;
                    mem_req_n = 1'b0;
                    if_ack_n  = 1'b1;
                    err_n     = !bus.mem_ready;
                    if (bus.mem_ready) begin
                        if_rdata_n = bus.mem_rdata;
                    end
                end
            end
            GNT_D: begin
                if (done) begin
                    state_n   = RESP;
                    mem_req_n = 1'b0;
                    d_ack_n   = 1'b1;
                    err_n     = !bus.mem_ready;
                    // writes complete without touching the read-data register
                    if (bus.mem_ready && bus.mem_we == '0) begin
                        d_rdata_n = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            streak        <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_rdata   <= '0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_n;
            streak        <= streak_n;
            bus.mem_req   <= mem_req_n;
            bus.mem_addr  <= addr_n;
            bus.mem_wdata <= wdata_n;
            bus.mem_we    <= we_n;
            bus.if_ack    <= if_ack_n;
            bus.if_rdata  <= if_rdata_n;
            bus.d_ack     <= d_ack_n;
            bus.d_rdata   <= d_rdata_n;
            bus.err       <= err_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus
// hand-written arbitration, starvation, timeout and reset sequences.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .DATA_BURST (4),
        .TIMEOUT    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic  is_d;
        be_t   we;
        addr_t addr;
        data_t wdata;
        data_t mrdata;
        int    delay;
        be_t   exp_we;
        data_t exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bus.if_req    = !v.is_d;
        bus.if_addr   = v.addr;
        bus.d_req     = v.is_d;
        bus.d_we      = v.we;
        bus.d_addr    = v.addr;
        bus.d_wdata   = v.wdata;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = v.mrdata;
        tick;
        chkb({tag, " mem_req"}, bus.mem_req, 1'b1);
        chk({tag, " mem_addr"}, bus.mem_addr, v.addr);
        chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(v.exp_we));
        if (v.is_d) chk({tag, " mem_wdata"}, bus.mem_wdata, v.wdata);
        for (int i = 0; i < v.delay; i++) tick;
        chkb({tag, " held"}, bus.mem_req, 1'b1);
        chkb({tag, " no early ack"}, bus.if_ack | bus.d_ack, 1'b0);
        bus.mem_ready = 1'b1;
        tick;
        chkb({tag, " if_ack"}, bus.if_ack, !v.is_d);
        chkb({tag, " d_ack"}, bus.d_ack, v.is_d);
        chkb({tag, " err"}, bus.err, 1'b0);
        chkb({tag, " resp mem_req"}, bus.mem_req, 1'b0);
        if (v.is_d) chk({tag, " d_rdata"}, bus.d_rdata, v.exp_rdata);
        else chk({tag, " if_rdata"}, bus.if_rdata, v.exp_rdata);
        bus.if_req    = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        tick;
        chkb({tag, " idle mem_req"}, bus.mem_req, 1'b0);
        chkb({tag, " idle ack"}, bus.if_ack | bus.d_ack, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic got[6];
        logic exp_order[6];
        int   nack;
        logic both;
        logic ack_seen;
        vec_t fv;

        vecs[0] = '{1'b0, 4'h0, 32'h100,  32'h0,        32'h00A00093, 0,  4'h0, 32'h00A00093};
        vecs[1] = '{1'b1, 4'h0, 32'h2000, 32'h0,        32'h12345678, 2,  4'h0, 32'h12345678};
        vecs[2] = '{1'b1, 4'hF, 32'h3000, 32'hCAFEF00D, 32'hFFFFFFFF, 1,  4'hF, 32'h12345678};
        vecs[3] = '{1'b1, 4'h3, 32'h4,    32'h0000BEEF, 32'h87654321, 0,  4'h3, 32'h12345678};
        vecs[4] = '{1'b0, 4'h0, 32'h104,  32'h0,        32'h00000013, 3,  4'h0, 32'h00000013};
        vecs[5] = '{1'b1, 4'h0, 32'h8,    32'h0,        32'hA5A5A5A5, 15, 4'h0, 32'hA5A5A5A5};

        rst           = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = '0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        tick;
        tick;
        chkb("rst mem_req", bus.mem_req, 1'b0);
        chkb("rst acks", bus.if_ack | bus.d_ack | bus.err, 1'b0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst rdata", bus.if_rdata | bus.d_rdata, 32'h0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // both request together: data first, then the fetch
        bus.d_req     = 1'b1;
        bus.d_we      = 4'hF;
        bus.d_addr    = 32'h8000;
        bus.d_wdata   = 32'hDEADBEEF;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h200;
        bus.mem_rdata = 32'h0F0F0F0F;
        tick;
        chk("sim d addr", bus.mem_addr, 32'h8000);
        chk("sim d we", 32'(bus.mem_we), 32'hF);
        chk("sim d wdata", bus.mem_wdata, 32'hDEADBEEF);
        bus.mem_ready = 1'b1;
        tick;
        chkb("sim d_ack", bus.d_ack, 1'b1);
        chkb("sim if_ack low", bus.if_ack, 1'b0);
        chk("sim d_rdata kept", bus.d_rdata, 32'hA5A5A5A5);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        tick;
        chkb("sim idle", bus.mem_req, 1'b0);
        tick;
        chk("sim i addr", bus.mem_addr, 32'h200);
        chk("sim i we", 32'(bus.mem_we), 32'h0);
        bus.mem_ready = 1'b1;
        tick;
        chkb("sim if_ack", bus.if_ack, 1'b1);
        chk("sim if_rdata", bus.if_rdata, 32'h0F0F0F0F);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick;

        // both held continuously: four data grants, one fetch, data again
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        nack = 0;
        both = 1'b0;
        bus.d_req     = 1'b1;
        bus.d_we      = 4'h0;
        bus.d_addr    = 32'h900;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h400;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h11110000;
        for (int cyc = 0; cyc < 60 && nack < 6; cyc++) begin
            tick;
            if (bus.if_ack && bus.d_ack) both = 1'b1;
            if (bus.if_ack || bus.d_ack) begin
                got[nack] = bus.if_ack;
                nack++;
            end
        end
        bus.d_req     = 1'b0;
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        chk("starve ack count", 32'(nack), 32'd6);
        for (int i = 0; i < 6; i++)
            chkb($sformatf("starve ack%0d is fetch", i), got[i], exp_order[i]);
        chkb("starve ack overlap", both, 1'b0);
        chk("starve if_rdata", bus.if_rdata, 32'h11110000);
        tick;

        // fetch never answered: err ack after sixteen stalled cycles
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h300;
        bus.mem_rdata = 32'h55555555;
        tick;
        chkb("to grant", bus.mem_req, 1'b1);
        for (int i = 0; i < 15; i++) tick;
        chkb("to still waiting", bus.mem_req, 1'b1);
        chkb("to no early ack", bus.if_ack, 1'b0);
        tick;
        chkb("to if_ack", bus.if_ack, 1'b1);
        chkb("to err", bus.err, 1'b1);
        chkb("to d_ack low", bus.d_ack, 1'b0);
        chkb("to mem_req low", bus.mem_req, 1'b0);
        chk("to if_rdata kept", bus.if_rdata, 32'h11110000);
        bus.if_req = 1'b0;
        tick;
        chkb("to idle err", bus.err, 1'b0);
        chkb("to idle ack", bus.if_ack, 1'b0);

        // reset while a data read is stalled
        bus.d_req  = 1'b1;
        bus.d_we   = 4'h0;
        bus.d_addr = 32'h40;
        tick;
        chkb("rm grant", bus.mem_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chkb("rm mem_req async", bus.mem_req, 1'b0);
        chkb("rm d_ack", bus.d_ack, 1'b0);
        chk("rm mem_addr", bus.mem_addr, 32'h0);
        chk("rm d_rdata", bus.d_rdata, 32'h0);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            ack_seen = ack_seen | bus.d_ack | bus.if_ack;
        end
        rst = 1'b1;
        tick;
        ack_seen = ack_seen | bus.d_ack | bus.if_ack;
        chkb("rm no ack", ack_seen, 1'b0);
        fv = '{1'b0, 4'h0, 32'h500, 32'h0, 32'h00100073, 0, 4'h0, 32'h00100073};
        run_vec(fv, "rm fetch");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
